bmd_tx_arbiter: RTL and testbench

Arbitrates the single 64-bit TX engine between two TLP sources: target completions requested by the RX engine for MemRd32 hits, and initiator MemWr32 TLPs requested by the local DMA/sniffer logic. It sits between the RX engine's `req_compl`/`compl_done` handshake, the initiator's request, and the TX engine's start/done interface. It enforces one TLP in flight, bounded completion priority, and a watchdog so a stalled TX engine never hangs a requester.

---
 rtl/bmd_tx_arbiter_if.sv | 56 +++++
 rtl/bmd_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bmd_tx_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bmd_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bmd_tx_arbiter_if
//  Description : Handshake bundle between the TX arbiter, its two requesters
//                (RX completion path and initiator MWr path) and the TX
//                engine's start/done interface.
//                  init_rst_i      synchronous abort of current arbitration
//                  cpl_req_i/cpl_done_o   completion request level / done pulse
//                  mwr_req_i/mwr_done_o   MWr request level / done pulse
//                  tx_cpl_start_o/tx_mwr_start_o  TX build-start pulses
//                  tx_done_i       TX engine finished the current TLP
//                  grant_o         one-hot owner, [0]=cpl, [1]=mwr
//                  timeout_o       watchdog expiry pulse
//                modport master : arbiter side
//                modport slave  : requesters / TX engine side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bmd_tx_arbiter_if;
    logic       init_rst_i;
    logic       cpl_req_i;
    logic       cpl_done_o;
    logic       mwr_req_i;
    logic       mwr_done_o;
    logic       tx_cpl_start_o;
    logic       tx_mwr_start_o;
    logic       tx_done_i;
    logic [1:0] grant_o;
    logic       timeout_o;

    modport master (
        input  init_rst_i,
        input  cpl_req_i,
        input  mwr_req_i,
        input  tx_done_i,
        output cpl_done_o,
        output mwr_done_o,
        output tx_cpl_start_o,
        output tx_mwr_start_o,
        output grant_o,
        output timeout_o
    );

    modport slave (
        output init_rst_i,
        output cpl_req_i,
        output mwr_req_i,
        output tx_done_i,
        input  cpl_done_o,
        input  mwr_done_o,
        input  tx_cpl_start_o,
        input  tx_mwr_start_o,
        input  grant_o,
        input  timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/bmd_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bmd_tx_arbiter
//  Description : Arbitrates the single 64-bit TX engine between target
//                completions (RX engine) and initiator MemWr32 TLPs. One TLP
//                in flight, completions win ties for at most MAX_CPL_BURST
//                consecutive grants while an MWr waits, and a watchdog forces
//                release of a grant if the TX engine never reports done.
//  Ports       : clk    - clock
//                rst_n  - synchronous active-low reset
//                bus    - bmd_tx_arbiter_if.master handshake bundle
//  Parameters  : MAX_CPL_BURST (1..15), TIMEOUT (1..65535)
//  Revision    : 1.0 - initial release
// ============================================================================
module bmd_tx_arbiter #(
    parameter int unsigned MAX_CPL_BURST = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bmd_tx_arbiter_if.master        bus
);

    localparam logic [3:0]  c_max_burst = 4'(MAX_CPL_BURST);
    // Watchdog counter value on the edge at which a stalled grant is released.
    localparam logic [15:0] c_wd_last   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_CPL = 2'd1,
        ST_GNT_MWR = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t      r_state,        w_state_nxt;
    logic [3:0]  r_cpl_streak,   w_cpl_streak_nxt;
    logic [15:0] r_wd_cnt,       w_wd_cnt_nxt;

    logic        r_cpl_done,     w_cpl_done_nxt;
    logic        r_mwr_done,     w_mwr_done_nxt;
    logic        r_cpl_start,    w_cpl_start_nxt;
    logic        r_mwr_start,    w_mwr_start_nxt;
    logic [1:0]  r_grant,        w_grant_nxt;
    logic        r_timeout,      w_timeout_nxt;

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Every output is registered, so the
    // *_nxt values here describe what is visible in the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cpl_streak_nxt = r_cpl_streak;
        w_wd_cnt_nxt     = r_wd_cnt;
        w_cpl_done_nxt   = 1'b0;
        w_mwr_done_nxt   = 1'b0;
        w_cpl_start_nxt  = 1'b0;
        w_mwr_start_nxt  = 1'b0;
        w_grant_nxt      = 2'b00;
        w_timeout_nxt    = 1'b0;

        if (bus.init_rst_i) begin
            // Abort wins over tx_done_i and watchdog expiry: no done pulse
            // is issued for the grant being dropped.
            w_state_nxt      = ST_IDLE;
            w_cpl_streak_nxt = 4'd0;
            w_wd_cnt_nxt     = 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cpl_req_i &&
                        (!bus.mwr_req_i || (r_cpl_streak != c_max_burst))) begin
                        w_state_nxt     = ST_GNT_CPL;
                        w_cpl_start_nxt = 1'b1;
                        w_grant_nxt     = 2'b01;
                        w_wd_cnt_nxt    = 16'd0;
                        // Only grants that make a waiting MWr wait longer
                        // count toward the burst limit.
                        if (!bus.mwr_req_i) begin
                            w_cpl_streak_nxt = 4'd0;
                        end else if (r_cpl_streak != c_max_burst) begin
                            w_cpl_streak_nxt = r_cpl_streak + 4'd1;
                        end
                    end else if (bus.mwr_req_i) begin
                        w_state_nxt      = ST_GNT_MWR;
                        w_mwr_start_nxt  = 1'b1;
                        w_grant_nxt      = 2'b10;
                        w_wd_cnt_nxt     = 16'd0;
                        w_cpl_streak_nxt = 4'd0;
                    end else begin
                        w_cpl_streak_nxt = 4'd0;
                    end
                end

                ST_GNT_CPL: begin
                    w_grant_nxt  = 2'b01;
                    w_wd_cnt_nxt = r_wd_cnt + 16'd1;
                    if (bus.tx_done_i) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_cpl_done_nxt = 1'b1;
                        w_grant_nxt    = 2'b00;
                    end else if (r_wd_cnt == c_wd_last) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_cpl_done_nxt = 1'b1;
                        w_timeout_nxt  = 1'b1;
                        w_grant_nxt    = 2'b00;
                    end
                end

                ST_GNT_MWR: begin
                    w_grant_nxt  = 2'b10;
                    w_wd_cnt_nxt = r_wd_cnt + 16'd1;
                    if (bus.tx_done_i) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_mwr_done_nxt = 1'b1;
                        w_grant_nxt    = 2'b00;
                    end else if (r_wd_cnt == c_wd_last) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_mwr_done_nxt = 1'b1;
                        w_timeout_nxt  = 1'b1;
                        w_grant_nxt    = 2'b00;
                    end
                end

                // A requester may keep its level high for one cycle after
                // its done pulse; skipping request sampling here keeps that
                // stale level from being re-granted.
                ST_HOLDOFF: begin
                    w_state_nxt = ST_IDLE;
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cpl_streak <= 4'd0;
            r_wd_cnt     <= 16'd0;
            r_cpl_done   <= 1'b0;
            r_mwr_done   <= 1'b0;
            r_cpl_start  <= 1'b0;
            r_mwr_start  <= 1'b0;
            r_grant      <= 2'b00;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpl_streak <= w_cpl_streak_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
            r_cpl_done   <= w_cpl_done_nxt;
            r_mwr_done   <= w_mwr_done_nxt;
            r_cpl_start  <= w_cpl_start_nxt;
            r_mwr_start  <= w_mwr_start_nxt;
            r_grant      <= w_grant_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign bus.cpl_done_o     = r_cpl_done;
    assign bus.mwr_done_o     = r_mwr_done;
    assign bus.tx_cpl_start_o = r_cpl_start;
    assign bus.tx_mwr_start_o = r_mwr_start;
    assign bus.grant_o        = r_grant;
    assign bus.timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bmd_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bmd_tx_arbiter
//  Description : Self-checking bench for bmd_tx_arbiter. Instance a uses
//                MAX_CPL_BURST=4 / TIMEOUT=8, instance b uses TIMEOUT=4.
//                Per-cycle vector table plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmd_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bmd_tx_arbiter_if ifa ();
    bmd_tx_arbiter_if ifb ();

    bmd_tx_arbiter #(.MAX_CPL_BURST(4), .TIMEOUT(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    bmd_tx_arbiter #(.MAX_CPL_BURST(4), .TIMEOUT(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Inputs applied before an edge; exp = outputs visible after that edge,
    // packed as {grant[1:0], cpl_start, mwr_start, cpl_done, mwr_done, timeout}.
    typedef struct {
        logic       rst_n;
        logic       init;
        logic       cpl;
        logic       mwr;
        logic       txd;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [25];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs_a();
        return {ifa.grant_o, ifa.tx_cpl_start_o, ifa.tx_mwr_start_o,
                ifa.cpl_done_o, ifa.mwr_done_o, ifa.timeout_o};
    endfunction

    function automatic logic [6:0] outs_b();
        return {ifb.grant_o, ifb.tx_cpl_start_o, ifb.tx_mwr_start_o,
                ifb.cpl_done_o, ifb.mwr_done_o, ifb.timeout_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [5:0] mwr_turn;
        logic       got_mwr;
        logic       found;

        ifa.init_rst_i = 1'b0; ifa.cpl_req_i = 1'b0; ifa.mwr_req_i = 1'b0; ifa.tx_done_i = 1'b0;
        ifb.init_rst_i = 1'b0; ifb.cpl_req_i = 1'b0; ifb.mwr_req_i = 1'b0; ifb.tx_done_i = 1'b0;

        //           rst_n init  cpl   mwr   txd   grant cs ms cd md to
        // Reset with both requests high, then cpl wins, then mwr.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b00_0_0_0_0_0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b00_0_0_0_0_0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b01_1_0_0_0_0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b01_0_0_0_0_0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'b00_0_0_1_0_0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b00_0_0_0_0_0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b10_0_1_0_0_0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b00_0_0_0_1_0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_0_0_0_0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0_0_0_0};
        // Single cpl: request at edge 0, tx_done at edge 5, stale level in HOLDOFF.
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_1_0_0_0_0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_0_0_0_0_0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_0_0_0_0_0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_0_0_0_0_0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_0_0_0_0_0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b00_0_0_1_0_0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b00_0_0_0_0_0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0_0_0_0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b00_0_0_0_0_0};
        // Abort coinciding with tx_done, then regrant straight from IDLE.
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_1_0_0_0_0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_0_0_0_0_0};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'b00_0_0_0_0_0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b01_1_0_0_0_0};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b00_0_0_1_0_0};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_0_0_0_0};

        for (int i = 0; i < 25; i++) begin
            rst_n          = vecs[i].rst_n;
            ifa.init_rst_i = vecs[i].init;
            ifa.cpl_req_i  = vecs[i].cpl;
            ifa.mwr_req_i  = vecs[i].mwr;
            ifa.tx_done_i  = vecs[i].txd;
            tick();
            check($sformatf("vec%0d", i), 32'(outs_a()), 32'(vecs[i].exp));
        end
        ifa.init_rst_i = 1'b0;
        ifa.tx_done_i  = 1'b0;
        check("b_idle_after_reset", 32'(outs_b()), 32'd0);

        // ---- Priority / burst: both held, expect cpl x4, mwr, cpl ----
        mwr_turn = 6'b01_0000;
        ifa.cpl_req_i = 1'b1;
        ifa.mwr_req_i = 1'b1;
        for (int g = 0; g < 6; g++) begin
            found   = 1'b0;
            got_mwr = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                tick();
                if (ifa.tx_cpl_start_o || ifa.tx_mwr_start_o) begin
                    found   = 1'b1;
                    got_mwr = ifa.tx_mwr_start_o;
                    check($sformatf("burst_start_excl%0d", g),
                          32'({ifa.tx_cpl_start_o, ifa.tx_mwr_start_o} == 2'b11), 32'd0);
                end
            end
            if (!found) begin
                n_cmp++;
                n_fail++;
                $display("FAIL burst_wait%0d: no start pulse within 10 cycles, expected one", g);
            end
            check($sformatf("burst_order%0d", g), 32'(got_mwr), 32'(mwr_turn[g]));
            tick();
            ifa.tx_done_i = 1'b1;
            tick();
            ifa.tx_done_i = 1'b0;
            check($sformatf("burst_done%0d", g), 32'({ifa.cpl_done_o, ifa.mwr_done_o}),
                  mwr_turn[g] ? 32'b01 : 32'b10);
            if (g == 5) begin
                ifa.cpl_req_i = 1'b0;
                ifa.mwr_req_i = 1'b0;
            end
        end
        tick();
        tick();
        check("burst_quiet", 32'(outs_a()), 32'd0);

        // ---- Watchdog on instance a (TIMEOUT=8) ----
        ifa.mwr_req_i = 1'b1;
        tick();
        check("wd_start", 32'(outs_a()), 32'b10_0_1_0_0_0);
        for (int j = 1; j < 8; j++) begin
            tick();
            check($sformatf("wd_wait%0d", j), 32'({ifa.timeout_o, ifa.mwr_done_o}), 32'd0);
        end
        tick();
        check("wd_expire", 32'(outs_a()), 32'b00_0_0_0_1_1);
        ifa.mwr_req_i = 1'b0;
        ifa.tx_done_i = 1'b1;
        tick();
        check("wd_late_done_holdoff", 32'(outs_a()), 32'd0);
        tick();
        check("wd_late_done_idle", 32'(outs_a()), 32'd0);
        ifa.tx_done_i = 1'b0;

        // ---- Coincidence on instance b (TIMEOUT=4) ----
        ifb.cpl_req_i = 1'b1;
        tick();
        check("coin_start", 32'(outs_b()), 32'b01_1_0_0_0_0);
        for (int j = 1; j < 4; j++) begin
            tick();
            check($sformatf("coin_wait%0d", j), 32'(outs_b()), 32'b01_0_0_0_0_0);
        end
        ifb.tx_done_i = 1'b1;
        tick();
        ifb.tx_done_i = 1'b0;
        check("coin_done_no_timeout", 32'(outs_b()), 32'b00_0_0_1_0_0);
        ifb.cpl_req_i = 1'b0;
        tick();
        tick();

        // ---- Abort on the expiry edge overrides the watchdog ----
        ifb.cpl_req_i = 1'b1;
        tick();
        check("abort_wd_start", 32'(outs_b()), 32'b01_1_0_0_0_0);
        tick();
        tick();
        tick();
        ifb.init_rst_i = 1'b1;
        tick();
        ifb.init_rst_i = 1'b0;
        check("abort_wd_quiet", 32'(outs_b()), 32'd0);
        tick();
        check("abort_wd_regrant", 32'(outs_b()), 32'b01_1_0_0_0_0);
        ifb.tx_done_i = 1'b1;
        tick();
        ifb.tx_done_i = 1'b0;
        check("abort_wd_regrant_done", 32'(outs_b()), 32'b00_0_0_1_0_0);
        ifb.cpl_req_i = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
